refresh_scheduler: RTL and testbench

REFRESH_SCHEDULER -- requirements
Module: refresh_scheduler

---
 rtl/dram_ctrl_pkg.sv | 20 ++
 rtl/trfc_timer.sv | 33 +++
 rtl/refresh_scheduler.sv | 145 ++++++++++++++
 tb/tb_refresh_scheduler.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dram_ctrl_pkg.sv
// Shared DRAM-controller types: command encodings and refresh scheduler states.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package dram_ctrl_pkg;

    typedef enum logic [1:0] {
        CMD_NOP   = 2'b00,
        CMD_READ  = 2'b01,
        CMD_WRITE = 2'b10,
        CMD_REF   = 2'b11
    } cmd_type_t;

    typedef enum logic [1:0] {
        IDLE     = 2'b00,
        HOST_CMD = 2'b01,
        REF_CMD  = 2'b10,
        REF_WAIT = 2'b11
    } sched_state_t;

endpackage

// File: rtl/trfc_timer.sv
// tRFC blackout countdown: load starts a CYCLES-long busy window, done flags its last cycle.
// Latency: busy from the cycle after load; done in the CYCLES-th busy cycle.
// Backpressure: none; load restarts the count unconditionally.
// Ports: clk, rst_b, load (start countdown), busy (count running), done (final busy cycle).
// CYCLES must be at least 1.
module trfc_timer #(
    parameter int CYCLES = 12
) (
    input  logic clk,
    input  logic rst_b,
    input  logic load,
    output logic busy,
    output logic done
);

    localparam int CW = $clog2(CYCLES + 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            count <= '0;
        end else if (load) begin
            count <= CW'(CYCLES);
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign busy = (count != '0);
    assign done = (count == CW'(1));

endmodule

// File: rtl/refresh_scheduler.sv
// Refresh scheduler: tracks postponed refreshes and interleaves REF commands with host traffic.
// Latency: command offered the cycle after host acceptance; REF followed by TRFC_CYCLES blackout.
// Backpressure: cmd_ready stalls the offered command; host_ready drops when busy or refresh is urgent.
// Ports: refresh_tick in; host_valid/host_write/host_addr/host_ready host side;
//        cmd_valid/cmd_ready/cmd_type/cmd_addr issuer side; pending_cnt/urgent/overflow status.
// Optional: define REFRESH_STATS_EN to add ref_issued_cnt (saturating count of REF handshakes).
module refresh_scheduler
    import dram_ctrl_pkg::*;
#(
    parameter int ADDR_W        = 24,
    parameter int MAX_PENDING   = 8,
    parameter int URGENT_THRESH = 4,
    parameter int TRFC_CYCLES   = 12
) (
    input  logic                             clk,
    input  logic                             rst_b,
    input  logic                             refresh_tick,
    input  logic                             host_valid,
    input  logic                             host_write,
    input  logic [ADDR_W-1:0]                host_addr,
    output logic                             host_ready,
    output logic                             cmd_valid,
    input  logic                             cmd_ready,
    output logic [1:0]                       cmd_type,
    output logic [ADDR_W-1:0]                cmd_addr,
    output logic [$clog2(MAX_PENDING+1)-1:0] pending_cnt,
    output logic                             urgent,
    output logic                             overflow
`ifdef REFRESH_STATS_EN
    ,
    output logic [15:0]                      ref_issued_cnt
`endif
);

    localparam int PCW = $clog2(MAX_PENDING + 1);

    sched_state_t state, state_nxt;
    cmd_type_t    lat_type;
    logic [ADDR_W-1:0] lat_addr;
    logic host_hs;
    logic ref_hs;
    logic trfc_busy;
    logic trfc_done;

    assign urgent     = (pending_cnt >= PCW'(URGENT_THRESH));
    assign host_ready = (state == IDLE) && !urgent;
    assign host_hs    = host_valid && host_ready;
    assign ref_hs     = (state == REF_CMD) && cmd_ready;

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cmd_valid = 1'b0;
        cmd_type  = CMD_NOP;
        cmd_addr  = '0;
        case (state)
            IDLE: begin
                if (urgent) begin
                    state_nxt = REF_CMD;
                end else if (host_valid) begin
                    state_nxt = HOST_CMD;
                end else if (pending_cnt != '0) begin
                    state_nxt = REF_CMD;
                end
            end
            HOST_CMD: begin
                cmd_valid = 1'b1;
                cmd_type  = lat_type;
                cmd_addr  = lat_addr;
                if (cmd_ready) begin
                    state_nxt = IDLE;
                end
            end
            REF_CMD: begin
                cmd_valid = 1'b1;
                cmd_type  = CMD_REF;
                if (cmd_ready) begin
                    state_nxt = REF_WAIT;
                end
            end
            REF_WAIT: begin
                // The !busy term only guards against wedging if the timer were ever idle here.
                if (trfc_done || !trfc_busy) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Request is captured at acceptance so the command stays stable while the issuer stalls.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            lat_type <= CMD_NOP;
            lat_addr <= '0;
        end else if (host_hs) begin
            lat_type <= host_write ? CMD_WRITE : CMD_READ;
            lat_addr <= host_addr;
        end
    end

    // A tick landing on a REF handshake cancels out; a tick at the ceiling is lost and flagged.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            pending_cnt <= '0;
            overflow    <= 1'b0;
        end else if (refresh_tick && !ref_hs) begin
            if (pending_cnt == PCW'(MAX_PENDING)) begin
                overflow <= 1'b1;
            end else begin
                pending_cnt <= pending_cnt + 1'b1;
            end
        end else if (!refresh_tick && ref_hs) begin
            pending_cnt <= pending_cnt - 1'b1;
        end
    end

    trfc_timer #(
        .CYCLES (TRFC_CYCLES)
    ) u_trfc_timer (
        .clk   (clk),
        .rst_b (rst_b),
        .load  (ref_hs),
        .busy  (trfc_busy),
        .done  (trfc_done)
    );

`ifdef REFRESH_STATS_EN
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            ref_issued_cnt <= '0;
        end else if (ref_hs && (ref_issued_cnt != 16'hFFFF)) begin
            ref_issued_cnt <= ref_issued_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_refresh_scheduler.sv
// Bench for refresh_scheduler: directed scenarios plus randomized traffic against a job-level model.
// Latency: n/a (testbench).
// Backpressure: cmd_ready driven randomly or per scenario.
module tb_refresh_scheduler;
    import dram_ctrl_pkg::*;

    localparam int ADDR_W = 24;
    localparam int MAXP   = 8;
    localparam int URG    = 4;
    localparam int TRFC   = 12;
    localparam int PCW    = $clog2(MAXP + 1);

    logic              clk;
    logic              rst_b;
    logic              refresh_tick;
    logic              host_valid;
    logic              host_write;
    logic [ADDR_W-1:0] host_addr;
    logic              host_ready;
    logic              cmd_valid;
    logic              cmd_ready;
    logic [1:0]        cmd_type;
    logic [ADDR_W-1:0] cmd_addr;
    logic [PCW-1:0]    pending_cnt;
    logic              urgent;
    logic              overflow;
`ifdef REFRESH_STATS_EN
    logic [15:0]       ref_issued_cnt;
`endif

    refresh_scheduler #(
        .ADDR_W        (ADDR_W),
        .MAX_PENDING   (MAXP),
        .URGENT_THRESH (URG),
        .TRFC_CYCLES   (TRFC)
    ) dut (
        .clk          (clk),
        .rst_b        (rst_b),
        .refresh_tick (refresh_tick),
        .host_valid   (host_valid),
        .host_write   (host_write),
        .host_addr    (host_addr),
        .host_ready   (host_ready),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_type     (cmd_type),
        .cmd_addr     (cmd_addr),
        .pending_cnt  (pending_cnt),
        .urgent       (urgent),
        .overflow     (overflow)
`ifdef REFRESH_STATS_EN
        ,
        .ref_issued_cnt (ref_issued_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]        t;
        logic [ADDR_W-1:0] a;
    } exp_cmd_t;

    exp_cmd_t exp_q[$];
    int total = 0;
    int bad   = 0;

    // Job-level reference model: a backlog of owed refreshes, at most one offered command,
    // and a number of blackout cycles still to serve after a refresh is taken.
    int       m_pend;
    bit       m_ovf;
    bit       m_offering;
    exp_cmd_t m_offer;
    int       m_blackout;
    int       m_refs;

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic void model_reset();
        m_pend     = 0;
        m_ovf      = 1'b0;
        m_offering = 1'b0;
        m_blackout = 0;
        m_refs     = 0;
        m_offer.t  = 2'b00;
        m_offer.a  = '0;
        exp_q.delete();
    endfunction

    function automatic void new_offer(logic [1:0] t, logic [ADDR_W-1:0] a);
        m_offer.t  = t;
        m_offer.a  = a;
        m_offering = 1'b1;
        exp_q.push_back(m_offer);
    endfunction

    // Advance the model by one clock given the inputs presented during that cycle.
    function automatic void model_step(bit tick, bit hv, bit hw, logic [ADDR_W-1:0] ha, bit crdy);
        int pend_old;
        bit ref_done;
        pend_old = m_pend;
        ref_done = m_offering && (m_offer.t == 2'b11) && crdy;
        if (tick && !ref_done) begin
            if (m_pend == MAXP) m_ovf = 1'b1;
            else m_pend++;
        end else if (!tick && ref_done) begin
            m_pend--;
        end
        if (m_offering) begin
            if (crdy) begin
                m_offering = 1'b0;
                if (m_offer.t == 2'b11) begin
                    m_blackout = TRFC;
                    if (m_refs < 16'hFFFF) m_refs++;
                end
            end
        end else if (m_blackout > 0) begin
            m_blackout--;
        end else if (pend_old >= URG) begin
            new_offer(2'b11, '0);
        end else if (hv) begin
            new_offer(hw ? 2'b10 : 2'b01, ha);
        end else if (pend_old > 0) begin
            new_offer(2'b11, '0);
        end
    endfunction

    function automatic void compare_outputs();
        bit idle;
        bit urg;
        idle = !m_offering && (m_blackout == 0);
        urg  = (m_pend >= URG);
        chk("pending_cnt", 64'(pending_cnt), 64'(m_pend));
        chk("urgent", 64'(urgent), 64'(urg));
        chk("host_ready", 64'(host_ready), 64'(idle && !urg));
        chk("overflow", 64'(overflow), 64'(m_ovf));
        chk("cmd_valid", 64'(cmd_valid), 64'(m_offering));
        if (m_offering) begin
            chk("cmd_type_hold", 64'(cmd_type), 64'(m_offer.t));
            chk("cmd_addr_hold", 64'(cmd_addr), 64'(m_offer.a));
        end else begin
            chk("cmd_type_nop", 64'(cmd_type), 64'(0));
            chk("cmd_addr_zero", 64'(cmd_addr), 64'(0));
        end
`ifdef REFRESH_STATS_EN
        chk("ref_issued_cnt", 64'(ref_issued_cnt), 64'(m_refs));
`endif
    endfunction

    task automatic step(bit tick, bit hv, bit hw, logic [ADDR_W-1:0] ha, bit crdy);
        @(negedge clk);
        compare_outputs();
        refresh_tick = tick;
        host_valid   = hv;
        host_write   = hw;
        host_addr    = ha;
        cmd_ready    = crdy;
        model_step(tick, hv, hw, ha, crdy);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_b        = 1'b0;
        refresh_tick = 1'b0;
        host_valid   = 1'b0;
        host_write   = 1'b0;
        host_addr    = '0;
        cmd_ready    = 1'b0;
        #1;
        model_reset();
        chk("rst_cmd_valid", 64'(cmd_valid), 64'(0));
        chk("rst_cmd_type", 64'(cmd_type), 64'(0));
        chk("rst_cmd_addr", 64'(cmd_addr), 64'(0));
        chk("rst_pending", 64'(pending_cnt), 64'(0));
        chk("rst_overflow", 64'(overflow), 64'(0));
        @(negedge clk);
        rst_b = 1'b1;
        #1;
        chk("host_ready_after_rst", 64'(host_ready), 64'(1));
        model_step(1'b0, 1'b0, 1'b0, '0, 1'b0);
    endtask

    // Monitor: on every issuer handshake the oldest expected command must match.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (rst_b && cmd_valid && cmd_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_cmd", 64'(cmd_type), 64'(0));
                end else begin
                    exp_cmd_t e;
                    e = exp_q.pop_front();
                    chk("sb_cmd_type", 64'(cmd_type), 64'(e.t));
                    chk("sb_cmd_addr", 64'(cmd_addr), 64'(e.a));
                end
            end
        end
    end

    initial begin
        rst_b        = 1'b0;
        refresh_tick = 1'b0;
        host_valid   = 1'b0;
        host_write   = 1'b0;
        host_addr    = '0;
        cmd_ready    = 1'b0;
        model_reset();
        do_reset();

        // Single tick while idle: one REF, then a TRFC blackout.
        step(1, 0, 0, '0, 1);
        for (int i = 0; i < 20; i++) step(0, 0, 0, '0, 1);

        // Host read arrives alongside the second owed refresh: READ goes first.
        step(1, 0, 0, '0, 0);
        step(1, 1, 0, 24'h000ABC, 1);
        for (int i = 0; i < 50; i++) step(0, 0, 0, '0, 1);
        chk("drain_pending_a", 64'(pending_cnt), 64'(0));

        // Continuous host traffic while refreshes pile up to the urgent threshold.
        for (int i = 0; i < 45; i++) begin
            step((i % 3 == 0) && (i < 12), 1, 1'($urandom), ADDR_W'($urandom), 1);
        end
        for (int i = 0; i < 80; i++) step(0, 0, 0, '0, 1);

        // Stalled issuer: nine ticks saturate the backlog and raise sticky overflow.
        for (int i = 0; i < 9; i++) step(1, 0, 0, '0, 0);
        step(0, 0, 0, '0, 0);
        chk("sat_pending", 64'(pending_cnt), 64'(MAXP));
        chk("overflow_set", 64'(overflow), 64'(1));
        for (int i = 0; i < 150; i++) step(0, 0, 0, '0, 1);
        chk("overflow_sticky", 64'(overflow), 64'(1));
        chk("drain_pending_b", 64'(pending_cnt), 64'(0));

        // Tick coinciding with a REF handshake at a backlog of three.
        for (int i = 0; i < 3; i++) step(1, 0, 0, '0, 0);
        step(1, 0, 0, '0, 1);
        step(0, 0, 0, '0, 0);
        chk("coincident_pending", 64'(pending_cnt), 64'(3));
        for (int i = 0; i < 60; i++) step(0, 0, 0, '0, 1);

        // Reset while in the tRFC blackout.
        step(1, 0, 0, '0, 1);
        for (int i = 0; i < 30 && m_blackout < 6; i++) step(0, 0, 0, '0, 1);
        do_reset();
        step(0, 0, 0, '0, 1);

        // Randomized traffic, with a reset dropped in the middle.
        for (int i = 0; i < 2500; i++) begin
            if (i == 1200) do_reset();
            step($urandom_range(0, 11) == 0, 1'($urandom), 1'($urandom),
                 ADDR_W'($urandom), $urandom_range(0, 3) != 0);
        end
        for (int i = 0; i < 200; i++) step(0, 0, 0, '0, 1);
        chk("queue_drained", 64'(exp_q.size()), 64'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
